array_burst_reader: RTL and testbench

- Read-side counterpart to the team's index-addressed array writers.
- Holds a DEPTH x WIDTH unpacked storage array, loaded through a single write port indexed modulo DEPTH.
- On command, streams a contiguous, wrap-around range of entries out over a valid/ready interface.
- Exposes a packed snapshot of the whole array for debug and compare logic.

---
 rtl/array_burst_reader_if.sv | 46 ++++
 rtl/array_burst_reader.sv | 180 ++++++++++++++++++
 tb/tb_array_burst_reader.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/array_burst_reader_if.sv
// Output stream bundle for array_burst_reader: valid/ready beat carrying entry data and its index.
// ARRAY_BURST_READER_PARITY_EN adds an even-parity bit that travels with out_data.
interface array_burst_reader_if #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
);
  localparam int IDX_W = $clog2(DEPTH);

  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [IDX_W-1:0] out_index;
`ifdef ARRAY_BURST_READER_PARITY_EN
  logic             out_parity;

  modport master (
    output out_valid,
    output out_data,
    output out_index,
    output out_parity,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_data,
    input  out_index,
    input  out_parity,
    output out_ready
  );
`else
  modport master (
    output out_valid,
    output out_data,
    output out_index,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_data,
    input  out_index,
    output out_ready
  );
`endif
endinterface

// File: rtl/array_burst_reader.sv
// DEPTH x WIDTH array with an index-modulo write port that streams a wrap-around range of entries
// over valid/ready. Optional out_parity is enabled by defining ARRAY_BURST_READER_PARITY_EN.
module array_burst_reader #(
  parameter  int DEPTH = 8,
  parameter  int WIDTH = 8,
  localparam int LW    = $clog2(DEPTH) + 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         wr_en,
  input  logic [31:0]                  wr_index,
  input  logic [WIDTH-1:0]             wr_data,
  input  logic                         start,
  input  logic [31:0]                  start_index,
  input  logic [LW-1:0]                length,
  array_burst_reader_if.master         rd,
  output logic                         busy,
  output logic                         done,
  output logic [DEPTH-1:0][WIDTH-1:0]  snapshot
);
  localparam int IDX_W = $clog2(DEPTH);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_STREAM = 2'd1;
  localparam logic [1:0] ST_DONE   = 2'd2;

  logic [WIDTH-1:0] mem_r [DEPTH];

  logic [1:0]       state_r,     state_s;
  logic [IDX_W-1:0] ptr_r,       ptr_s;
  logic [LW-1:0]    rem_r,       rem_s;
  logic             out_valid_r, out_valid_s;
  logic [WIDTH-1:0] out_data_r,  out_data_s;
  logic [IDX_W-1:0] out_index_r, out_index_s;
  logic             busy_r,      busy_s;
  logic             done_r,      done_s;

  logic [IDX_W-1:0] wr_idx_s;
  logic [IDX_W-1:0] start_idx_s;
  logic [IDX_W-1:0] next_ptr_s;
  logic [LW-1:0]    len_clamp_s;
  logic [WIDTH-1:0] start_rd_s;
  logic [WIDTH-1:0] next_rd_s;
  logic             handshake_s;
  logic             unused_s;

  function automatic logic even_parity(input logic [WIDTH-1:0] d);
    return ^d;
  endfunction

  // Indices are reduced two's-complement modulo DEPTH; upper bits are intentionally dropped.
  assign wr_idx_s    = wr_index[IDX_W-1:0];
  assign start_idx_s = start_index[IDX_W-1:0];
  assign unused_s    = ^{wr_index[31:IDX_W], start_index[31:IDX_W]};
  assign next_ptr_s  = ptr_r + {{(IDX_W-1){1'b0}}, 1'b1};
  assign len_clamp_s = (length > LW'(DEPTH)) ? LW'(DEPTH) : length;
  assign handshake_s = out_valid_r & rd.out_ready;

  // Same-cycle writes to the entry being loaded are forwarded so the beat carries the new value.
  assign start_rd_s = (wr_en && (wr_idx_s == start_idx_s)) ? wr_data : mem_r[start_idx_s];
  assign next_rd_s  = (wr_en && (wr_idx_s == next_ptr_s))  ? wr_data : mem_r[next_ptr_s];

  // Next-state and next-output computation for the burst FSM.
  always_comb begin
    state_s     = state_r;
    ptr_s       = ptr_r;
    rem_s       = rem_r;
    out_valid_s = out_valid_r;
    out_data_s  = out_data_r;
    out_index_s = out_index_r;
    busy_s      = busy_r;
    done_s      = 1'b0;
    case (state_r)
      ST_IDLE: begin
        busy_s = 1'b0;
        if (start) begin
          busy_s = 1'b1;
          if (len_clamp_s != {LW{1'b0}}) begin
            state_s     = ST_STREAM;
            ptr_s       = start_idx_s;
            rem_s       = len_clamp_s;
            out_valid_s = 1'b1;
            out_data_s  = start_rd_s;
            out_index_s = start_idx_s;
          end else begin
            state_s = ST_DONE;
            done_s  = 1'b1;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_STREAM: begin
        busy_s = 1'b1;
        if (handshake_s) begin
          if (rem_r > LW'(1)) begin
            ptr_s       = next_ptr_s;
            rem_s       = rem_r - LW'(1);
            out_data_s  = next_rd_s;
            out_index_s = next_ptr_s;
          end else begin
            rem_s       = {LW{1'b0}};
            out_valid_s = 1'b0;
            state_s     = ST_DONE;
            done_s      = 1'b1;
          end
        end else begin
          state_s = ST_STREAM;
        end
      end
      ST_DONE: begin
        state_s = ST_IDLE;
        busy_s  = 1'b0;
      end
      default: begin
        state_s     = ST_IDLE;
        out_valid_s = 1'b0;
        busy_s      = 1'b0;
      end
    endcase
  end

  // Storage, FSM state and registered stream outputs; reset abandons any burst without a done.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {WIDTH{1'b0}};
      end
      state_r     <= ST_IDLE;
      ptr_r       <= {IDX_W{1'b0}};
      rem_r       <= {LW{1'b0}};
      out_valid_r <= 1'b0;
      out_data_r  <= {WIDTH{1'b0}};
      out_index_r <= {IDX_W{1'b0}};
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      if (wr_en) begin
        mem_r[wr_idx_s] <= wr_data;
      end
      state_r     <= state_s;
      ptr_r       <= ptr_s;
      rem_r       <= rem_s;
      out_valid_r <= out_valid_s;
      out_data_r  <= out_data_s;
      out_index_r <= out_index_s;
      busy_r      <= busy_s;
      done_r      <= done_s;
    end
  end

`ifdef ARRAY_BURST_READER_PARITY_EN
  logic out_parity_r;

  // Parity follows out_data_s, so it inherits forwarding and hold-under-backpressure.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_parity_r <= 1'b0;
    end else begin
      out_parity_r <= even_parity(out_data_s);
    end
  end

  assign rd.out_parity = out_parity_r;
`endif

  // Packed debug view straight off the storage array.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      snapshot[i] = mem_r[i];
    end
  end

  assign rd.out_valid = out_valid_r;
  assign rd.out_data  = out_data_r;
  assign rd.out_index = out_index_r;
  assign busy         = busy_r;
  assign done         = done_r;

endmodule

// File: tb/tb_array_burst_reader.sv
// Directed scoreboard bench for array_burst_reader: expected beats are queued at start, popped on handshake.
module tb_array_burst_reader;
  localparam int DEPTH = 8;
  localparam int WIDTH = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en;
  logic [31:0] wr_index;
  logic [7:0]  wr_data;
  logic        start;
  logic [31:0] start_index;
  logic [3:0]  length;
  logic        busy;
  logic        done;
  logic [7:0][7:0] snapshot;

  array_burst_reader_if #(.DEPTH(DEPTH), .WIDTH(WIDTH)) rd ();

  array_burst_reader #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .wr_en       (wr_en),
    .wr_index    (wr_index),
    .wr_data     (wr_data),
    .start       (start),
    .start_index (start_index),
    .length      (length),
    .rd          (rd),
    .busy        (busy),
    .done        (done),
    .snapshot    (snapshot)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int beats  = 0;
  int dones  = 0;
  logic [7:0]  model [DEPTH];
  logic [10:0] exp_q [$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] model_snap();
    logic [63:0] s;
    for (int i = 0; i < DEPTH; i++) s[i*8 +: 8] = model[i];
    return s;
  endfunction

  task automatic push_burst(input int s, input int n);
    for (int j = 0; j < n; j++) begin
      logic [2:0] idx;
      idx = 3'((s + j) % DEPTH);
      exp_q.push_back({idx, model[idx]});
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Passes start edge, then counts negedges until done; checks latency and single-cycle pulse.
  task automatic wait_done(input int exp_k, input string tag);
    int k;
    logic seen;
    k = 0;
    seen = 1'b0;
    cyc();
    start = 1'b0;
    wr_en = 1'b0;
    repeat (40) begin
      @(negedge clk);
      k++;
      if (done === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    check({tag, "_done_seen"}, 64'(seen), 64'd1);
    check({tag, "_latency"}, 64'(k), 64'(exp_k));
    check({tag, "_busy_at_done"}, 64'(busy), 64'd1);
    @(negedge clk);
    check({tag, "_done_pulse"}, 64'(done), 64'd0);
    check({tag, "_busy_after"}, 64'(busy), 64'd0);
    cyc();
  endtask

  // Scoreboard: every accepted beat must match the head of the expected queue.
  always @(negedge clk) begin
    if (rst !== 1'b1) begin
      if (done === 1'b1) dones++;
      if (rd.out_valid === 1'b1 && rd.out_ready === 1'b1) begin
        logic [10:0] e;
        beats++;
        checks++;
        assert (exp_q.size() != 0) else begin
          errors++;
          $error("FAIL unexpected_beat: observed idx %0d data 0x%0h, expected no beat", rd.out_index, rd.out_data);
        end
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("beat_index", 64'(rd.out_index), 64'(e[10:8]));
          check("beat_data", 64'(rd.out_data), 64'(e[7:0]));
`ifdef ARRAY_BURST_READER_PARITY_EN
          check("beat_parity", 64'(rd.out_parity), 64'(^e[7:0]));
`endif
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int b0;
    int d0;
    rst = 1'b1; wr_en = 1'b0; wr_index = 32'd0; wr_data = 8'd0;
    start = 1'b0; start_index = 32'd0; length = 4'd0; rd.out_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) model[i] = 8'h00;

    // Reset state
    cyc(); cyc();
    @(negedge clk);
    check("rst_snapshot", 64'(snapshot), 64'h0);
    check("rst_valid", 64'(rd.out_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_data", 64'(rd.out_data), 64'd0);
    check("rst_index", 64'(rd.out_index), 64'd0);
    cyc();
    rst = 1'b0;

    // Fill and full burst
    for (int i = 0; i < DEPTH; i++) begin
      wr_en = 1'b1; wr_index = 32'(i); wr_data = 8'(8'h10 + i);
      model[i] = 8'(8'h10 + i);
      cyc();
    end
    wr_en = 1'b0;
    @(negedge clk);
    check("fill_snapshot", 64'(snapshot), model_snap());
    cyc();
    b0 = beats; d0 = dones;
    rd.out_ready = 1'b1;
    start = 1'b1; start_index = 32'd0; length = 4'd8;
    push_burst(0, 8);
    wait_done(9, "full");
    check("full_beats", 64'(beats - b0), 64'd8);
    check("full_dones", 64'(dones - d0), 64'd1);

    // Wrap and negative index
    wr_en = 1'b1; wr_index = 32'hFFFF_FFFF; wr_data = 8'hAA;
    model[7] = 8'hAA;
    cyc();
    wr_en = 1'b0;
    start = 1'b1; start_index = 32'hFFFF_FFFE; length = 4'd3;
    push_burst(6, 3);
    b0 = beats;
    wait_done(4, "wrap");
    check("wrap_beats", 64'(beats - b0), 64'd3);
    check("wrap_snapshot", 64'(snapshot), model_snap());

    // Backpressure with overwrite of the presented entry
    b0 = beats;
    start = 1'b1; start_index = 32'd2; length = 4'd2;
    push_burst(2, 2);
    rd.out_ready = 1'b0;
    cyc();
    start = 1'b0;
    wr_en = 1'b1; wr_index = 32'd2; wr_data = 8'h55;
    repeat (5) begin
      @(negedge clk);
      check("bp_valid", 64'(rd.out_valid), 64'd1);
      check("bp_data", 64'(rd.out_data), 64'h12);
      check("bp_index", 64'(rd.out_index), 64'd2);
`ifdef ARRAY_BURST_READER_PARITY_EN
      check("bp_parity", 64'(rd.out_parity), 64'(^8'h12));
`endif
      cyc();
    end
    model[2] = 8'h55;
    wr_en = 1'b0;
    rd.out_ready = 1'b1;
    wait_done(2, "bp");
    check("bp_beats", 64'(beats - b0), 64'd2);
    check("bp_snapshot", 64'(snapshot), model_snap());

    // Forwarding on the start load
    wr_en = 1'b1; wr_index = 32'd3; wr_data = 8'h3C;
    start = 1'b1; start_index = 32'd3; length = 4'd1;
    model[3] = 8'h3C;
    push_burst(3, 1);
    b0 = beats;
    wait_done(2, "fwd");
    check("fwd_beats", 64'(beats - b0), 64'd1);

    // Zero length: no beat
    b0 = beats;
    start = 1'b1; start_index = 32'd4; length = 4'd0;
    wait_done(1, "len0");
    check("len0_beats", 64'(beats - b0), 64'd0);

    // Over-length clamps to DEPTH
    b0 = beats;
    start = 1'b1; start_index = 32'd5; length = 4'd15;
    push_burst(5, 8);
    wait_done(9, "clamp");
    check("clamp_beats", 64'(beats - b0), 64'd8);

    // Reset after the 3rd accepted beat
    b0 = beats; d0 = dones;
    start = 1'b1; start_index = 32'd0; length = 4'd8;
    push_burst(0, 8);
    cyc();
    start = 1'b0;
    cyc(); cyc(); cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    @(negedge clk);
    check("mid_rst_valid", 64'(rd.out_valid), 64'd0);
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_snapshot", 64'(snapshot), 64'h0);
    repeat (3) @(negedge clk);
    check("mid_rst_beats", 64'(beats - b0), 64'd3);
    check("mid_rst_no_done", 64'(dones - d0), 64'd0);
    exp_q.delete();
    for (int i = 0; i < DEPTH; i++) model[i] = 8'h00;
    cyc();
    b0 = beats;
    start = 1'b1; start_index = 32'd4; length = 4'd2;
    push_burst(4, 2);
    wait_done(3, "post_rst");
    check("post_rst_beats", 64'(beats - b0), 64'd2);

    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
